// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter with round-robin contention, whole-cycle grant
// hold and a stalled-beat watchdog that aborts the current owner with an error.
module wshb_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_ms,
  input  logic [3:0]  m0_sel,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic [31:0] m0_dat_sm,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_ms,
  input  logic [3:0]  m1_sel,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic [31:0] m1_dat_sm,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_ms,
  output logic [3:0]  s_sel,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  input  logic [31:0] s_dat_sm,
  input  logic        s_ack,
  input  logic        s_err,
  output logic [1:0]  grant,
  output logic        wdt_abort
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arbState_t;

  arbState_t   state;
  logic        lastGrant;
  logic [15:0] wdtCount;
  logic        stallBeat;
  logic        wdtExpire;

  // A stalled beat is an owned, strobed beat that the slave has not terminated.
  always_comb begin
    stallBeat = 1'b0;
    if ((state == GNT0) || (state == GNT1)) begin
      stallBeat = s_stb & ~s_ack & ~s_err;
    end else begin
      stallBeat = 1'b0;
    end
  end

  assign wdtExpire = stallBeat && (wdtCount == 16'(TIMEOUT - 32'd1));

  // Arbitration state, round-robin history and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      wdtCount  <= 16'd0;
    end else begin
      if (stallBeat) begin
        wdtCount <= wdtCount + 16'd1;
      end else begin
        wdtCount <= 16'd0;
      end
      case (state)
        IDLE: begin
          if (m0_cyc && m1_cyc) begin
            // Contention goes to whoever did not own the bus last.
            if (lastGrant) begin
              state     <= GNT0;
              lastGrant <= 1'b0;
            end else begin
              state     <= GNT1;
              lastGrant <= 1'b1;
            end
          end else if (m0_cyc) begin
            state     <= GNT0;
            lastGrant <= 1'b0;
          end else if (m1_cyc) begin
            state     <= GNT1;
            lastGrant <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GNT0: begin
          if (wdtExpire) begin
            state <= ABORT;
          end else if (!m0_cyc) begin
            state <= IDLE;
          end else begin
            state <= GNT0;
          end
        end
        GNT1: begin
          if (wdtExpire) begin
            state <= ABORT;
          end else if (!m1_cyc) begin
            state <= IDLE;
          end else begin
            state <= GNT1;
          end
        end
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner's bus to the slave and the slave's termination back to it.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = 32'h0000_0000;
    s_dat_ms  = 32'h0000_0000;
    s_sel     = 4'h0;
    s_cti     = 3'b000;
    s_bte     = 2'b00;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    grant     = 2'b00;
    wdt_abort = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        m0_err   = s_err;
        grant    = 2'b01;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        m1_err   = s_err;
        grant    = 2'b10;
      end
      ABORT: begin
        wdt_abort = 1'b1;
        if (lastGrant) begin
          m1_err = 1'b1;
        end else begin
          m0_err = 1'b1;
        end
      end
      IDLE:    grant = 2'b00;
      default: grant = 2'b00;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed-vector bench for wshb_arbiter: each vector pushes its expected outputs
// into a scoreboard queue that a negedge monitor pops and compares.
module tb_wshb_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm, m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  grant;
  logic        wdt_abort;

  // stim = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}
  // flags = {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, wdt_abort}
  typedef struct packed {
    logic [6:0] stim;
    logic [2:0] cti;
    logic [1:0] eg;
    logic [6:0] flags;
  } row_t;

  typedef struct packed {
    logic [15:0] idx;
    logic [1:0]  grant;
    logic [6:0]  flags;
    logic [73:0] bus;
    logic [31:0] datSm;
  } exp_t;

  row_t rows[$];
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  wshb_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_dat_sm(s_dat_sm),
    .s_ack(s_ack), .s_err(s_err), .grant(grant), .wdt_abort(wdt_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addRow(input logic [6:0] stim, input logic [2:0] cti,
                        input logic [1:0] eg, input logic [6:0] flags);
    row_t r;
    r.stim  = stim;
    r.cti   = cti;
    r.eg    = eg;
    r.flags = flags;
    rows.push_back(r);
  endtask

  // Scoreboard monitor: compare one expected record per falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if ({grant, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, wdt_abort} !== {e.grant, e.flags}) begin
        errors++;
        $display("FAIL ctrl row %0d: got grant=%b flags=%b, expected grant=%b flags=%b",
                 e.idx, grant, {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, wdt_abort},
                 e.grant, e.flags);
      end
      checks++;
      if ({s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte} !== e.bus) begin
        errors++;
        $display("FAIL bus row %0d: got %h, expected %h", e.idx,
                 {s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}, e.bus);
      end
      checks++;
      if ({m0_dat_sm, m1_dat_sm} !== {e.datSm, e.datSm}) begin
        errors++;
        $display("FAIL datsm row %0d: got %h/%h, expected %h", e.idx, m0_dat_sm, m1_dat_sm, e.datSm);
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = 6'b000000;
    m0_we = 1'b1; m1_we = 1'b0; m0_sel = 4'hF; m1_sel = 4'h3;
    m0_bte = 2'b00; m1_bte = 2'b01; m0_cti = 3'b000; m1_cti = 3'b000;
    m0_adr = 32'h0; m1_adr = 32'h0; m0_dat_ms = 32'h0; m1_dat_ms = 32'h0; s_dat_sm = 32'h0;

    // Reset holds everything quiet even with requests present.
    addRow(7'b1000000, 3'b000, 2'b00, 7'b0000000);
    addRow(7'b1111100, 3'b000, 2'b00, 7'b0000000);
    // Contention after reset: m0 first, then m1 after one idle cycle.
    addRow(7'b0111100, 3'b000, 2'b00, 7'b0000000);
    addRow(7'b0111110, 3'b000, 2'b01, 7'b1110000);
    addRow(7'b0001100, 3'b000, 2'b01, 7'b0000000);
    addRow(7'b0001100, 3'b000, 2'b00, 7'b0000000);
    addRow(7'b0001110, 3'b000, 2'b10, 7'b1100100);
    addRow(7'b0000000, 3'b000, 2'b10, 7'b0000000);
    // Fairness: both keep re-requesting single beats.
    for (int k = 0; k < 4; k++) begin
      addRow(7'b0111100, 3'b000, 2'b00, 7'b0000000);
      addRow(7'b0111110, 3'b000, 2'b01, 7'b1110000);
      addRow(7'b0001100, 3'b000, 2'b01, 7'b0000000);
      addRow(7'b0111100, 3'b000, 2'b00, 7'b0000000);
      addRow(7'b0111110, 3'b000, 2'b10, 7'b1100100);
      addRow(7'b0110000, 3'b000, 2'b10, 7'b0000000);
    end
    // m1 eight-beat incrementing burst while m0 waits.
    addRow(7'b0001100, 3'b000, 2'b00, 7'b0000000);
    for (int k = 0; k < 7; k++) begin
      addRow(7'b0111110, 3'b010, 2'b10, 7'b1100100);
    end
    addRow(7'b0111110, 3'b111, 2'b10, 7'b1100100);
    addRow(7'b0110000, 3'b000, 2'b10, 7'b0000000);
    addRow(7'b0110000, 3'b000, 2'b00, 7'b0000000);
    // Watchdog: four stalled beats, then a one-cycle abort to m0.
    for (int k = 0; k < 4; k++) begin
      addRow(7'b0110000, 3'b000, 2'b01, 7'b1100000);
    end
    addRow(7'b0110000, 3'b000, 2'b00, 7'b0001001);
    // After abort, round-robin favours m1.
    addRow(7'b0111100, 3'b000, 2'b00, 7'b0000000);
    addRow(7'b0111110, 3'b000, 2'b10, 7'b1100100);
    addRow(7'b0110000, 3'b000, 2'b10, 7'b0000000);
    addRow(7'b0110000, 3'b000, 2'b00, 7'b0000000);
    // m0 burst interrupted by reset on beat 3, then regranted.
    addRow(7'b0110010, 3'b010, 2'b01, 7'b1110000);
    addRow(7'b0110010, 3'b010, 2'b01, 7'b1110000);
    addRow(7'b1110010, 3'b010, 2'b00, 7'b0000000);
    addRow(7'b0110000, 3'b000, 2'b00, 7'b0000000);
    addRow(7'b0110001, 3'b000, 2'b01, 7'b1101000);
    addRow(7'b0110010, 3'b000, 2'b01, 7'b1110000);
    addRow(7'b0000000, 3'b000, 2'b01, 7'b0000000);
    addRow(7'b0000000, 3'b000, 2'b00, 7'b0000000);

    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk);
      #1;
      {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = rows[i].stim;
      m0_cti    = rows[i].cti;
      m1_cti    = rows[i].cti;
      m0_adr    = 32'h1000_0000 + 32'(i * 4);
      m1_adr    = 32'h2000_0000 + 32'(i * 4);
      m0_dat_ms = 32'hA000_0000 + 32'(i);
      m1_dat_ms = 32'hB000_0000 + 32'(i);
      s_dat_sm  = 32'hD000_0000 + 32'(i);
      e.idx   = 16'(i);
      e.grant = rows[i].eg;
      e.flags = rows[i].flags;
      e.datSm = s_dat_sm;
      if (rows[i].eg == 2'b01) begin
        e.bus = {1'b1, m0_adr, m0_dat_ms, 4'hF, rows[i].cti, 2'b00};
      end else if (rows[i].eg == 2'b10) begin
        e.bus = {1'b0, m1_adr, m1_dat_ms, 4'h3, rows[i].cti, 2'b01};
      end else begin
        e.bus = 74'd0;
      end
      expQ.push_back(e);
    end

    @(posedge clk);
    #1;
    {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = 7'b0000000;
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
